// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: pipelined Kogge-Stone adder/subtractor with valid/ready streaming
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      input handshake (in_ready is combinational from out_ready)
//   in_x, in_y               operands (WIDTH bits)
//   in_cin                   carry-in (borrow-in with inverted sense when subtracting)
//   in_sub                   1 = x - y, 0 = x + y
//   in_tag                   sideband returned unchanged with the result
//   out_valid / out_ready    output handshake
//   out_sum                  result (WIDTH bits)
//   out_cout                 carry out of the MSB (1 = no borrow when subtracting)
//   out_ovf                  signed two's-complement overflow
//   out_zero                 out_sum == 0
//   out_tag                  tag of the beat on the output
module prefix_adder_pipe #(
    parameter int WIDTH       = 16,
    parameter int LVL_PER_STG = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int LOG2W = $clog2(WIDTH);
    localparam int NSTG  = (LOG2W + LVL_PER_STG - 1) / LVL_PER_STG;
    localparam int LAT   = 1 + NSTG;

    logic [LAT-1:0]   r_v;
    logic [LAT-1:0]   w_rdy;
    logic             w_acc;
    logic [WIDTH-1:0] w_yp;
    logic [WIDTH-1:0] w_g0;
    logic [WIDTH-1:0] w_p0;
    logic [WIDTH-1:0] w_h0;
    logic             w_c0;
    logic [WIDTH-1:0] r_g   [NSTG];
    logic [WIDTH-1:0] r_p   [NSTG];
    logic [WIDTH-1:0] r_h   [NSTG];
    logic             r_c0  [NSTG];
    logic [TAG_W-1:0] r_tag [NSTG];
    logic [WIDTH-1:0] w_gn  [NSTG];
    logic [WIDTH-1:0] w_pn  [NSTG];
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic [TAG_W-1:0] r_otag;

    assign w_yp = in_sub ? ~in_y : in_y;
    assign w_c0 = in_cin ^ in_sub;
    assign w_p0 = in_x | w_yp;
    assign w_h0 = in_x ^ w_yp;
    // The carry-in acts as the generate of a virtual bit -1; merging it into
    // bit 0 up front keeps every carry span within LOG2W prefix levels.
    assign w_g0 = (in_x & w_yp) | {{(WIDTH-1){1'b0}}, w_p0[0] & w_c0};

    // A stage is ready if it or any stage downstream of it has a free slot,
    // or the consumer is taking the output beat.
    always_comb begin
        w_acc = out_ready;
        w_rdy = '0;
        for (int k = LAT - 1; k >= 0; k--) begin
            w_acc    = w_acc | ~r_v[k];
            w_rdy[k] = w_acc;
        end
    end

    assign in_ready = w_rdy[0] & ~rst;

    // Stage k applies prefix levels k*LVL_PER_STG .. (k+1)*LVL_PER_STG-1.
    // Bits are updated from the top down so each reads its lower partner
    // before that partner is overwritten; levels past LOG2W are identity.
    always_comb begin
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        for (int k = 0; k < NSTG; k++) begin
            g = r_g[k];
            p = r_p[k];
            for (int l = 0; l < LVL_PER_STG; l++) begin
                if (k * LVL_PER_STG + l < LOG2W) begin
                    for (int i = WIDTH - 1; i >= (1 << (k * LVL_PER_STG + l)); i--) begin
                        g[i] = g[i] | (p[i] & g[i - (1 << (k * LVL_PER_STG + l))]);
                        p[i] = p[i] & p[i - (1 << (k * LVL_PER_STG + l))];
                    end
                end
            end
            w_gn[k] = g;
            w_pn[k] = p;
        end
    end

    // c[0] is the folded carry-in; c[i+1] is the full-span generate of bit i.
    assign w_c   = {w_gn[NSTG-1], r_c0[NSTG-1]};
    assign w_sum = r_h[NSTG-1] ^ w_c[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v    <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_otag <= '0;
        end else begin
            if (w_rdy[0]) begin
                r_v[0]   <= in_valid;
                r_g[0]   <= w_g0;
                r_p[0]   <= w_p0;
                r_h[0]   <= w_h0;
                r_c0[0]  <= w_c0;
                r_tag[0] <= in_tag;
            end
            for (int k = 1; k < NSTG; k++) begin
                if (w_rdy[k]) begin
                    r_v[k]   <= r_v[k-1];
                    r_g[k]   <= w_gn[k-1];
                    r_p[k]   <= w_pn[k-1];
                    r_h[k]   <= r_h[k-1];
                    r_c0[k]  <= r_c0[k-1];
                    r_tag[k] <= r_tag[k-1];
                end
            end
            if (w_rdy[LAT-1]) begin
                r_v[LAT-1] <= r_v[LAT-2];
                r_sum      <= w_sum;
                r_cout     <= w_c[WIDTH];
                r_ovf      <= w_c[WIDTH] ^ w_c[WIDTH-1];
                r_zero     <= ~|w_sum;
                r_otag     <= r_tag[NSTG-1];
            end
        end
    end

    assign out_valid = r_v[LAT-1];
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;
    assign out_zero  = r_zero;
    assign out_tag   = r_otag;
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// tb_prefix_adder_pipe: directed and exhaustive checks of prefix_adder_pipe
module tb_prefix_adder_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        in_cin;
    logic        in_sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;
    logic [3:0]  out_tag;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [5:0]  b_in_x;
    logic [5:0]  b_in_y;
    logic        b_in_cin;
    logic        b_in_sub;
    logic [3:0]  b_in_tag;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [5:0]  b_out_sum;
    logic        b_out_cout;
    logic        b_out_ovf;
    logic        b_out_zero;
    logic [3:0]  b_out_tag;

    int n_chk;
    int n_fail;
    logic [3:0]  got_tag [$];
    logic [15:0] got_sum [$];

    prefix_adder_pipe #(.WIDTH(16), .LVL_PER_STG(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
        .out_tag(out_tag)
    );

    prefix_adder_pipe #(.WIDTH(6), .LVL_PER_STG(3), .TAG_W(4)) dut6 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_x(b_in_x), .in_y(b_in_y), .in_cin(b_in_cin), .in_sub(b_in_sub), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_cout(b_out_cout), .out_ovf(b_out_ovf), .out_zero(b_out_zero),
        .out_tag(b_out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_one(input logic [15:0] x, input logic [15:0] y, input logic cin,
                            input logic sub, input logic [3:0] tag,
                            output int lat, output logic [22:0] res);
        int t;
        @(negedge clk);
        in_x = x; in_y = y; in_cin = cin; in_sub = sub; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 99;
        res = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                res = {out_sum, out_cout, out_ovf, out_zero, out_tag};
                break;
            end
        end
    endtask

    task automatic pump(input int n_send, input int t0, input int pat, input int n_want);
        int sent;
        int cyc;
        sent = 0;
        cyc = 0;
        got_tag.delete();
        got_sum.delete();
        while (got_tag.size() < n_want && cyc < 200) begin
            in_valid  = (sent < n_send);
            in_x      = 16'(16'h0100 * (t0 + sent));
            in_y      = 16'(t0 + sent);
            in_tag    = 4'(t0 + sent);
            in_cin    = 1'b0;
            in_sub    = 1'b0;
            out_ready = (pat == 0) ? 1'b1 : (pat == 1) ? (cyc % 2 == 0) : 1'b0;
            #1;
            if (out_valid && out_ready) begin
                got_tag.push_back(out_tag);
                got_sum.push_back(out_sum);
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_handshake: got out_valid,in_ready=%b want 00", {out_valid, in_ready});
        end
        n_chk++;
        if ({out_sum, out_cout, out_ovf, out_zero, out_tag} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {out_sum, out_cout, out_ovf, out_zero, out_tag});
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_arith;
        logic [15:0] tx  [7] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0005, 16'h1234, 16'h8000};
        logic [15:0] ty  [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h0005, 16'h4321, 16'h8000};
        logic        tc  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        ts  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0]  tt  [7] = '{4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
        logic [22:0] exp [7] = '{{16'h0000, 1'b1, 1'b0, 1'b1, 4'd5},
                                 {16'h8000, 1'b0, 1'b1, 1'b0, 4'd1},
                                 {16'h7FFF, 1'b1, 1'b1, 1'b0, 4'd2},
                                 {16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd3},
                                 {16'h0000, 1'b1, 1'b0, 1'b1, 4'd4},
                                 {16'h5556, 1'b0, 1'b0, 1'b0, 4'd6},
                                 {16'h0000, 1'b1, 1'b1, 1'b1, 4'd7}};
        int lat;
        logic [22:0] res;
        for (int v = 0; v < 7; v++) begin
            send_one(tx[v], ty[v], tc[v], ts[v], tt[v], lat, res);
            n_chk++;
            if (lat !== 3) begin
                n_fail++;
                $display("FAIL arith[%0d] latency: got %0d want 3", v, lat);
            end
            n_chk++;
            if (res !== exp[v]) begin
                n_fail++;
                $display("FAIL arith[%0d] sum,cout,ovf,zero,tag: got %h want %h", v, res, exp[v]);
            end
        end
    endtask

    task automatic test_stream;
        int bad;
        pump(8, 0, 1, 8);
        n_chk++;
        if (got_tag.size() != 8) begin
            n_fail++;
            $display("FAIL stream_count: got %0d want 8", got_tag.size());
        end
        for (int i = 0; i < got_tag.size(); i++) begin
            n_chk++;
            if ({got_tag[i], got_sum[i]} !== {4'(i), 16'(16'h0101 * i)}) begin
                n_fail++;
                $display("FAIL stream_beat[%0d]: got tag %h sum %h want tag %h sum %h",
                         i, got_tag[i], got_sum[i], 4'(i), 16'(16'h0101 * i));
            end
        end
        bad = 0;
        repeat (3) begin
            #1;
            if (out_valid) bad++;
            @(negedge clk);
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stream_no_dup: got %0d extra valid cycles want 0", bad);
        end
    endtask

    task automatic test_full_stall;
        int acc;
        int bad;
        logic [19:0] snap;
        logic        snap_v;
        acc = 0;
        bad = 0;
        snap = '0;
        snap_v = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_cin = 1'b0; in_sub = 1'b0;
            in_x = 16'(16'h0100 * (8 + acc)); in_y = 16'(8 + acc); in_tag = 4'(8 + acc);
            #1;
            if (c == 3) begin
                snap = {out_sum, out_tag};
                snap_v = out_valid;
            end
            if (c > 3 && ({out_valid, out_sum, out_tag} !== {1'b1, snap})) bad++;
            if (in_valid && in_ready) acc++;
        end
        n_chk++;
        if (acc != 3) begin
            n_fail++;
            $display("FAIL stall_capacity: got %0d accepted want 3", acc);
        end
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
        n_chk++;
        if ({snap_v, snap} !== {1'b1, 16'h0808, 4'd8}) begin
            n_fail++;
            $display("FAIL stall_head: got %h want %h", {snap_v, snap}, {1'b1, 16'h0808, 4'd8});
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_stable: got %0d changed cycles want 0", bad);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_x = 16'h0B00; in_y = 16'd11; in_tag = 4'd11; in_valid = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_push_pop_ready: got %b want 1", in_ready);
        end
        pump(1, 11, 0, 4);
        n_chk++;
        if (got_tag.size() != 4) begin
            n_fail++;
            $display("FAIL drain_count: got %0d want 4", got_tag.size());
        end
        for (int i = 0; i < got_tag.size(); i++) begin
            n_chk++;
            if ({got_tag[i], got_sum[i]} !== {4'(8 + i), 16'(16'h0101 * (8 + i))}) begin
                n_fail++;
                $display("FAIL drain_beat[%0d]: got tag %h sum %h want tag %h sum %h",
                         i, got_tag[i], got_sum[i], 4'(8 + i), 16'(16'h0101 * (8 + i)));
            end
        end
    endtask

    task automatic test_mid_reset;
        int lat;
        int bad;
        logic [22:0] res;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_cin = 1'b0; in_sub = 1'b0;
            in_x = 16'(16'h0100 * (c + 1)); in_y = 16'(c + 1); in_tag = 4'(c + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_chk++;
        if ({out_valid, out_sum, out_tag} !== {1'b1, 16'h0101, 4'd1}) begin
            n_fail++;
            $display("FAIL midrst_preload: got %h want %h", {out_valid, out_sum, out_tag}, {1'b1, 16'h0101, 4'd1});
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_in_ready_during: got %b want 0", in_ready);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag} !== 24'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h want 0", {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag});
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_in_ready_after: got %b want 1", in_ready);
        end
        out_ready = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (out_valid) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midrst_stale_beat: got %0d valid cycles want 0", bad);
        end
        send_one(16'h00FF, 16'h0001, 1'b0, 1'b0, 4'hA, lat, res);
        n_chk++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL midrst_latency: got %0d want 3", lat);
        end
        n_chk++;
        if (res !== {16'h0100, 1'b0, 1'b0, 1'b0, 4'hA}) begin
            n_fail++;
            $display("FAIL midrst_result: got %h want %h", res, {16'h0100, 1'b0, 1'b0, 1'b0, 4'hA});
        end
    endtask

    task automatic test_exhaustive6;
        logic [12:0] exp_q [$];
        logic [12:0] e;
        logic [5:0]  yp;
        logic [6:0]  full;
        logic        ovf;
        int sent;
        int rcv;
        int cyc;
        int first_acc;
        sent = 0;
        rcv = 0;
        cyc = 0;
        first_acc = 0;
        @(negedge clk);
        while (rcv < 16384 && cyc < 60000) begin
            b_in_valid = (sent < 16384);
            {b_in_sub, b_in_cin, b_in_x, b_in_y} = 14'(sent);
            b_in_tag = 4'(sent);
            b_out_ready = (cyc < 4) || ($urandom_range(0, 3) != 0);
            #1;
            if (b_out_valid && b_out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
                n_chk++;
                if ({b_out_sum, b_out_cout, b_out_ovf, b_out_zero, b_out_tag} !== e) begin
                    n_fail++;
                    $display("FAIL w6_beat[%0d]: got %h want %h", rcv,
                             {b_out_sum, b_out_cout, b_out_ovf, b_out_zero, b_out_tag}, e);
                end
                if (rcv == 0) begin
                    n_chk++;
                    if (cyc - first_acc != 2) begin
                        n_fail++;
                        $display("FAIL w6_latency: got %0d want 2", cyc - first_acc);
                    end
                end
                rcv++;
            end
            if (b_in_valid && b_in_ready) begin
                yp   = b_in_sub ? ~b_in_y : b_in_y;
                full = {1'b0, b_in_x} + {1'b0, yp} + {6'd0, b_in_cin ^ b_in_sub};
                ovf  = (b_in_x[5] == yp[5]) && (full[5] != b_in_x[5]);
                exp_q.push_back({full[5:0], full[6], ovf, full[5:0] == 6'd0, b_in_tag});
                if (sent == 0) first_acc = cyc;
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        b_in_valid = 1'b0;
        n_chk++;
        if (rcv != 16384) begin
            n_fail++;
            $display("FAIL w6_count: got %0d want 16384", rcv);
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_x = '0; in_y = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
        out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_x = '0; b_in_y = '0; b_in_cin = 1'b0; b_in_sub = 1'b0; b_in_tag = '0;
        b_out_ready = 1'b1;
        test_reset;
        test_arith;
        @(negedge clk);
        test_stream;
        test_full_stall;
        test_mid_reset;
        test_exhaustive6;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/prefix_adder_pipe.md
Name: prefix_adder_pipe

Overview:
- Parametrised, pipelined parallel-prefix (Kogge-Stone) adder/subtractor with valid/ready streaming handshake.
- Generalises the team's fixed 6-bit combinational prefix adder with:
  - arbitrary width, carry-in and subtract mode
  - signed-overflow and zero flags
  - a sideband tag
  - configurable pipeline depth with per-stage backpressure
- Sits in the datapath wherever multi-cycle add/sub results must be streamed at full throughput.

Parameters:
- WIDTH, 16: operand/sum width in bits; must be >= 2.
- LVL_PER_STG, 2: prefix levels computed between pipeline registers; must be >= 1.
- TAG_W, 4: sideband tag width; must be >= 1.
- Derived: LOG2W = ceil(log2(WIDTH)); LAT = 1 + ceil(LOG2W / LVL_PER_STG). Defaults give LAT = 3.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_x  in  WIDTH  operand x.
- in_y  in  WIDTH  operand y.
- in_cin  in  1  carry-in (borrow-in when subtracting, inverted sense).
- in_sub  in  1  1 = x - y, 0 = x + y.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of bit WIDTH-1.
- out_ovf  out  1  signed two's-complement overflow.
- out_zero  out  1  out_sum == 0.
- out_tag  out  TAG_W  tag of this beat.

Behaviour:

Arithmetic
- y' = in_sub ? ~in_y : in_y.
- c0 = in_cin ^ in_sub.
- Per bit i: g = x&y', p = x|y', h = x^y'.
- c0 is folded in as the generate of a virtual bit -1.
- Kogge-Stone prefix: level j combines spans at distance 2^j, for j = 0..LOG2W-1.
  - dot operator: G = Gh | (Ph & Gl); P = Ph & Pl.
- sum[i] = h[i] ^ c[i].
- out_cout = c[WIDTH].
- out_ovf = c[WIDTH] ^ c[WIDTH-1].
- out_zero = ~|sum.
- Subtract: out_cout = 1 means no borrow.
- Result must equal (x + y' + c0) mod 2^(WIDTH+1) for all inputs.

Pipeline
- Stage 0 registers g, p, h, c0, tag on acceptance.
- Each subsequent stage computes LVL_PER_STG prefix levels and registers them.
- The last stage forms sum and flags combinationally from its registered prefix and registers them into the output stage.
- Total register stages = LAT.
- Timing: a beat accepted in cycle n (in_valid & in_ready) has out_valid high in cycle n+LAT when nothing stalls.

Handshake
- Each stage k holds valid_k.
- ready_k = ~valid_k | ready_{k+1}; ready of the output stage = ~out_valid | out_ready.
- in_ready = ready_0 & ~rst. The path from out_ready to in_ready is combinational.
- A stage loads when its ready is high. Bubbles collapse, so a stalled tail does not block empty upstream stages.
- Capacity = LAT beats. With out_ready held low, in_ready falls after LAT accepted beats.
- Ordering is strictly FIFO: no beat is dropped or duplicated.
- While out_valid=1 and out_ready=0, all out_* are stable.
- in_* are ignored when in_valid=0. in_valid may be asserted without waiting for in_ready.
- Simultaneous output pop and input push on a full pipeline: both occur in the same cycle, so throughput is 1 beat/cycle.

Reset
- While rst=1: all valid_k = 0; out_valid = 0; out_sum, out_cout, out_ovf, out_zero, out_tag = 0; in_ready = 0.
- Reset mid-operation discards every in-flight beat; no stale beat ever appears afterwards.
- First cycle after rst falls: in_ready = 1.

Boundaries
- WIDTH not a power of 2: prefix spans beyond bit -1 are treated as identity (G=0, P=1).
- LVL_PER_STG >= LOG2W: LAT = 2.

Test Plan:
- Defaults, x=0xFFFF, y=0x0001, cin=0, sub=0, tag=5, accepted cycle 0 -> cycle 3: out_sum=0x0000, cout=1, ovf=0, zero=1, tag=5.
- x=0x7FFF, y=0x0001, add -> sum=0x8000, cout=0, ovf=1, zero=0. Then x=0x8000, y=0x0001, sub=1, cin=0 -> sum=0x7FFF, cout=1, ovf=1.
- Sub with borrow-in: x=0x0005, y=0x0005, sub=1, cin=1 -> sum=0xFFFF, cout=0, ovf=0. Same operands with cin=0 -> sum=0x0000, zero=1, cout=1.
- Stream 8 beats (tags 0..7), in_valid held high, out_ready pattern 1,0,1,0,... -> all 8 results in tag order, none lost or duplicated. With out_ready held low, in_ready=0 after exactly 3 accepted beats; outputs stable during the stall.
- 3 beats in flight, rst pulsed 1 cycle -> out_valid=0 during and after reset until new input arrives. in_ready=1 the cycle after reset. First new beat emerges exactly 3 cycles after acceptance.
- WIDTH=6, LVL_PER_STG=3 (LAT=2): exhaustive x, y, cin, sub (16384 beats) streamed at full rate with random out_ready -> every result matches the reference model; latency 2 when unstalled.
